// File: rtl/aes_pkg.sv
// Shared AES constants, the SubBytes FSM state type and byte-position helpers.
// Byte 0 of a block is the most significant byte (FIPS-197 column-major order).
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Bit position of the least significant bit of byte idx within a block.
    function automatic int byte_lsb(input int idx);
        return AES_BLOCK_W - AES_BYTE_W * (idx + 1);
    endfunction

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward AES S-box as a purely combinational 256-entry lookup.
// Entry 0 sits in the most significant byte of the table constant.
module sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] plain_byte,
    output logic [AES_BYTE_W-1:0] sub_byte
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x lives at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
    assign sub_byte = SBOX_TABLE[{~plain_byte, 3'b000} +: AES_BYTE_W];

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes LANES bytes of the held block per cycle.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid holds until then.
module aes_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int NUM_GROUPS = AES_NUM_BYTES / LANES;
    localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

    generate
        if (!lanes_legal(LANES)) begin : g_bad_lanes
            $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    aes_state_e             state_q;
    aes_state_e             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_BLOCK_W-1:0] data_q;

    logic [AES_BYTE_W-1:0] lane_in  [LANES];
    logic [AES_BYTE_W-1:0] lane_out [LANES];

    // Lane l of group cnt works on byte cnt*LANES + l of the held block.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = data_q[byte_lsb(int'(cnt_q) * LANES + l) +: AES_BYTE_W];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            sbox u_sbox (
                .plain_byte (lane_in[g]),
                .sub_byte   (lane_out[g])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)             state_d = SUB;
            SUB:     if (cnt_q == LAST_GROUP)  state_d = DONE;
            DONE:    if (out_ready)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Block register doubles as the output register, so out_data never sees in_data combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        cnt_q  <= '0;
                    end
                end
                SUB: begin
                    for (int l = 0; l < LANES; l++) begin
                        data_q[byte_lsb(int'(cnt_q) * LANES + l) +: AES_BYTE_W] <= lane_out[l];
                    end
                    cnt_q <= (cnt_q == LAST_GROUP) ? '0 : cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule
